// File: rtl/cpu_hazard_scoreboard_pkg.sv
// cpu_hazard_scoreboard_pkg
// Shared encodings for the hazard controller: forward selects, the PC-source
// and result-source codes it decodes, and the interrupt-take FSM states.
// Also holds the forward-select priority helper used by the top.
package cpu_hazard_scoreboard_pkg;

    // Forward select encodings driven toward the E-stage operand muxes.
    localparam logic [1:0] FORWARD_NONE      = 2'b00;
    localparam logic [1:0] FORWARD_WRITEBACK = 2'b01;
    localparam logic [1:0] FORWARD_MEMORY    = 2'b10;

    // PC source encodings; anything other than PC+4 is a redirect.
    localparam logic [2:0] PC_SRC_PC_PLUS_4 = 3'd0;
    localparam logic [2:0] PC_SRC_BRANCH    = 3'd1;
    localparam logic [2:0] PC_SRC_JALR      = 3'd2;
    localparam logic [2:0] PC_SRC_TRAP      = 3'd3;

    // Result source encodings; DATA marks a load whose value arrives in M.
    localparam logic [2:0] RESULT_SRC_ALU       = 3'd0;
    localparam logic [2:0] RESULT_SRC_DATA      = 3'd1;
    localparam logic [2:0] RESULT_SRC_PC_PLUS_4 = 3'd2;
    localparam logic [2:0] RESULT_SRC_CSR       = 3'd3;

    // Interrupt-take FSM states.
    localparam logic [1:0] HZ_RUN   = 2'd0;
    localparam logic [1:0] HZ_DRAIN = 2'd1;
    localparam logic [1:0] HZ_TAKE  = 2'd2;

    // The M stage holds the younger result, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
        logic [1:0] sel;
        if (m_hit) begin
            sel = FORWARD_MEMORY;
        end else if (w_hit) begin
            sel = FORWARD_WRITEBACK;
        end else begin
            sel = FORWARD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/cpu_hazard_scoreboard_if.sv
// cpu_hazard_scoreboard_if
// Bundles the pipeline-side view of the hazard controller: D/E/M/W stage
// information, long-unit issue/retire, interrupt request (master -> slave),
// and forward selects, stalls, flushes, int_take, pending_count, sb_error
// (slave -> master). The hazard controller uses the slave modport.
interface cpu_hazard_scoreboard_if #(
    parameter int RA_W  = 5,
    parameter int CSR_W = 12,
    parameter int CNT_W = 3
);
    logic [RA_W-1:0]  rs1_d, rs2_d, rd_d;
    logic             uses_rs1_d, uses_rs2_d, long_op_d, exception_d, fence_d;
    logic [RA_W-1:0]  rs1_e, rs2_e, rd_e;
    logic [CSR_W-1:0] csrs_e;
    logic [2:0]       pc_src_e, result_src_e;
    logic             csr_write_e, long_issue_e;
    logic             reg_write_m, csr_write_m;
    logic [RA_W-1:0]  rd_m;
    logic [CSR_W-1:0] csrs_m;
    logic             reg_write_w, csr_write_w;
    logic [RA_W-1:0]  rd_w;
    logic [CSR_W-1:0] csrs_w;
    logic             long_done;
    logic [RA_W-1:0]  long_done_rd;
    logic             int_req;
    logic [1:0]       forward_a_e, forward_b_e, forward_csr_e;
    logic             stall_f, stall_d, flush_d, flush_e, flush_m, int_take;
    logic [CNT_W-1:0] pending_count;
    logic             sb_error;

    modport master (
        output rs1_d, rs2_d, rd_d, uses_rs1_d, uses_rs2_d, long_op_d, exception_d, fence_d,
        output rs1_e, rs2_e, rd_e, csrs_e, pc_src_e, result_src_e, csr_write_e, long_issue_e,
        output reg_write_m, csr_write_m, rd_m, csrs_m, reg_write_w, csr_write_w, rd_w, csrs_w,
        output long_done, long_done_rd, int_req,
        input  forward_a_e, forward_b_e, forward_csr_e, stall_f, stall_d,
        input  flush_d, flush_e, flush_m, int_take, pending_count, sb_error
    );

    modport slave (
        input  rs1_d, rs2_d, rd_d, uses_rs1_d, uses_rs2_d, long_op_d, exception_d, fence_d,
        input  rs1_e, rs2_e, rd_e, csrs_e, pc_src_e, result_src_e, csr_write_e, long_issue_e,
        input  reg_write_m, csr_write_m, rd_m, csrs_m, reg_write_w, csr_write_w, rd_w, csrs_w,
        input  long_done, long_done_rd, int_req,
        output forward_a_e, forward_b_e, forward_csr_e, stall_f, stall_d,
        output flush_d, flush_e, flush_m, int_take, pending_count, sb_error
    );
endinterface

// File: rtl/cpu_hazard_scoreboard_fifo.sv
// cpu_scoreboard_fifo
// In-order FIFO of destination registers of outstanding long operations.
// Ports: push/push_rd enqueue, pop/pop_rd retire the head; q0..q2 are
// parallel lookup keys with hit0..hit2 results (rd 0 never matches);
// head_rd, count, full, empty status; push_err/pop_err/rd_err protocol flags.
module cpu_scoreboard_fifo #(
    parameter int DEPTH = 4,
    parameter int RA_W  = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [RA_W-1:0]  push_rd,
    input  logic             pop,
    input  logic [RA_W-1:0]  pop_rd,
    input  logic [RA_W-1:0]  q0,
    input  logic [RA_W-1:0]  q1,
    input  logic [RA_W-1:0]  q2,
    output logic             hit0,
    output logic             hit1,
    output logic             hit2,
    output logic [RA_W-1:0]  head_rd,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             push_err,
    output logic             pop_err,
    output logic             rd_err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [RA_W-1:0]  mem_r [DEPTH];
    logic [DEPTH-1:0] vld_r;
    logic [PTR_W-1:0] head_r, tail_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s, do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    assign empty     = (count_r == '0);
    assign full      = (count_r == CNT_W'(DEPTH));
    assign count     = count_r;
    assign head_rd   = mem_r[head_r];
    // A pop frees the slot this cycle, so a push into a full FIFO is legal then.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign pop_err   = pop & empty;
    assign push_err  = push & full & ~pop;
    assign rd_err    = do_pop_s & (pop_rd != mem_r[head_r]);

    // Storage, valid bits, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            vld_r   <= '0;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_pop_s) begin
                vld_r[head_r] <= 1'b0;
                head_r        <= ptr_inc(head_r);
            end
            // Push after pop: when full, head and tail share a slot and the push must win.
            if (do_push_s) begin
                mem_r[tail_r] <= push_rd;
                vld_r[tail_r] <= 1'b1;
                tail_r        <= ptr_inc(tail_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Parallel lookup of the three keys against every valid nonzero entry.
    always_comb begin
        hit0 = 1'b0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_r[i] && (mem_r[i] != '0)) begin
                hit0 = hit0 | (mem_r[i] == q0);
                hit1 = hit1 | (mem_r[i] == q1);
                hit2 = hit2 | (mem_r[i] == q2);
            end else begin
                hit0 = hit0;
            end
        end
    end
endmodule

// File: rtl/cpu_hazard_scoreboard.sv
// cpu_hazard_scoreboard
// Pipeline hazard controller: operand/CSR forwarding, load-use and
// long-operation scoreboard stalls, fence/exception draining, branch flushes,
// and a RUN/DRAIN/TAKE interrupt sequencer.
// Ports: clk, rst (async active-high), hz (slave side of the hazard bus).
module cpu_hazard_scoreboard
    import cpu_hazard_scoreboard_pkg::*;
#(
    parameter int RA_W        = 5,
    parameter int CSR_W       = 12,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_hazard_scoreboard_if.slave hz
);
    logic [1:0]       state_r, state_nxt_s;
    logic             sb_error_r;
    logic [CNT_W-1:0] count_s;
    logic             full_s, empty_s, hit0_s, hit1_s, hit2_s;
    logic             push_err_s, pop_err_s, rd_err_s;
    logic [RA_W-1:0]  head_rd_s, q0_s, q1_s, q2_s;
    logic             lw_stall_s, sb_stall_s, exc_stall_s, jump_flush_s, hz_stall_s;

    // Unused source operands look up register 0, which never matches.
    assign q0_s = hz.uses_rs1_d ? hz.rs1_d : '0;
    assign q1_s = hz.uses_rs2_d ? hz.rs2_d : '0;
    assign q2_s = hz.rd_d;

    cpu_scoreboard_fifo #(.DEPTH(MAX_PENDING), .RA_W(RA_W), .CNT_W(CNT_W)) u_fifo (
        .clk(clk), .rst(rst),
        .push(hz.long_issue_e), .push_rd(hz.rd_e),
        .pop(hz.long_done), .pop_rd(hz.long_done_rd),
        .q0(q0_s), .q1(q1_s), .q2(q2_s),
        .hit0(hit0_s), .hit1(hit1_s), .hit2(hit2_s),
        .head_rd(head_rd_s), .count(count_s), .full(full_s), .empty(empty_s),
        .push_err(push_err_s), .pop_err(pop_err_s), .rd_err(rd_err_s)
    );

    // Operand and CSR forward selects.
    always_comb begin
        hz.forward_a_e   = fwd_sel(hz.reg_write_m && (hz.rd_m != '0) && (hz.rd_m == hz.rs1_e),
                                   hz.reg_write_w && (hz.rd_w != '0) && (hz.rd_w == hz.rs1_e));
        hz.forward_b_e   = fwd_sel(hz.reg_write_m && (hz.rd_m != '0) && (hz.rd_m == hz.rs2_e),
                                   hz.reg_write_w && (hz.rd_w != '0) && (hz.rd_w == hz.rs2_e));
        hz.forward_csr_e = fwd_sel(hz.csr_write_m && (hz.csrs_m == hz.csrs_e),
                                   hz.csr_write_w && (hz.csrs_w == hz.csrs_e));
    end

    assign lw_stall_s   = (hz.result_src_e == RESULT_SRC_DATA) && (hz.rd_e != '0) &&
                          ((hz.uses_rs1_d && (hz.rs1_d == hz.rd_e)) ||
                           (hz.uses_rs2_d && (hz.rs2_d == hz.rd_e)));
    // A retiring op frees a slot this cycle, so a full table need not stall a new long op.
    assign sb_stall_s   = hit0_s | hit1_s | hit2_s | (hz.long_op_d & full_s & ~hz.long_done) |
                          (hz.fence_d & ~empty_s);
    assign exc_stall_s  = hz.exception_d & (hz.csr_write_e | hz.csr_write_m | ~empty_s);
    assign jump_flush_s = (hz.pc_src_e != PC_SRC_PC_PLUS_4);
    assign hz_stall_s   = lw_stall_s | sb_stall_s | exc_stall_s;

    // Interrupt sequencer next state; entry waits out a redirect in E so the target is not lost.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            HZ_RUN: begin
                if (hz.int_req && !jump_flush_s) begin
                    state_nxt_s = HZ_DRAIN;
                end else begin
                    state_nxt_s = HZ_RUN;
                end
            end
            HZ_DRAIN: begin
                if (!hz.int_req) begin
                    state_nxt_s = HZ_RUN;
                end else if (empty_s && !hz.long_issue_e && !hz.long_done) begin
                    state_nxt_s = HZ_TAKE;
                end else begin
                    state_nxt_s = HZ_DRAIN;
                end
            end
            HZ_TAKE: state_nxt_s = HZ_RUN;
            default: state_nxt_s = HZ_RUN;
        endcase
    end

    // State register and sticky protocol error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= HZ_RUN;
            sb_error_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sb_error_r <= sb_error_r | push_err_s | pop_err_s | rd_err_s;
        end
    end

    // Stall/flush/take decode per sequencer state.
    always_comb begin
        hz.stall_f  = 1'b0;
        hz.stall_d  = 1'b0;
        hz.flush_d  = 1'b0;
        hz.flush_e  = 1'b0;
        hz.flush_m  = 1'b0;
        hz.int_take = 1'b0;
        case (state_r)
            HZ_RUN: begin
                hz.stall_f = hz_stall_s;
                hz.stall_d = hz_stall_s;
                hz.flush_d = jump_flush_s;
                hz.flush_e = jump_flush_s | hz_stall_s;
            end
            HZ_DRAIN: begin
                hz.stall_f = 1'b1;
                hz.stall_d = 1'b1;
                hz.flush_e = 1'b1;
            end
            HZ_TAKE: begin
                hz.flush_d  = 1'b1;
                hz.flush_e  = 1'b1;
                hz.flush_m  = 1'b1;
                hz.int_take = 1'b1;
            end
            default: begin
                hz.stall_f = 1'b0;
            end
        endcase
    end

    assign hz.pending_count = count_s;
    assign hz.sb_error      = sb_error_r;
endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// Directed bench for cpu_hazard_scoreboard with hand-computed expectations.
module tb_cpu_hazard_scoreboard;
    import cpu_hazard_scoreboard_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    cpu_hazard_scoreboard_if #(.RA_W(5), .CSR_W(12), .CNT_W(3)) hz_if ();

    cpu_hazard_scoreboard #(.RA_W(5), .CSR_W(12), .MAX_PENDING(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .hz(hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp = n_cmp + 1;
        if (obs !== exp_v) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hz_if.rs1_d = '0; hz_if.rs2_d = '0; hz_if.rd_d = '0;
        hz_if.uses_rs1_d = 1'b0; hz_if.uses_rs2_d = 1'b0; hz_if.long_op_d = 1'b0;
        hz_if.exception_d = 1'b0; hz_if.fence_d = 1'b0;
        hz_if.rs1_e = '0; hz_if.rs2_e = '0; hz_if.rd_e = '0; hz_if.csrs_e = '0;
        hz_if.pc_src_e = PC_SRC_PC_PLUS_4; hz_if.result_src_e = RESULT_SRC_ALU;
        hz_if.csr_write_e = 1'b0; hz_if.long_issue_e = 1'b0;
        hz_if.reg_write_m = 1'b0; hz_if.csr_write_m = 1'b0; hz_if.rd_m = '0; hz_if.csrs_m = '0;
        hz_if.reg_write_w = 1'b0; hz_if.csr_write_w = 1'b0; hz_if.rd_w = '0; hz_if.csrs_w = '0;
        hz_if.long_done = 1'b0; hz_if.long_done_rd = '0; hz_if.int_req = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd);
        clr();
        hz_if.long_issue_e = 1'b1;
        hz_if.rd_e = rd;
        tick();
        clr();
    endtask

    task automatic retire(input logic [4:0] rd);
        clr();
        hz_if.long_done = 1'b1;
        hz_if.long_done_rd = rd;
        tick();
        clr();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        clr();
        #2;
        // Reset state
        check_val("rst_count", 32'(hz_if.pending_count), 32'd0);
        check_val("rst_err", 32'(hz_if.sb_error), 32'd0);
        check_val("rst_fwd_a", 32'(hz_if.forward_a_e), 32'(FORWARD_NONE));
        check_val("rst_take", 32'(hz_if.int_take), 32'd0);
        check_val("rst_stall", 32'(hz_if.stall_f), 32'd0);
        check_val("rst_flush_e", 32'(hz_if.flush_e), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Forwarding: M over W, x0 never forwards, CSR forward from W
        hz_if.rs1_e = 5'd5; hz_if.rs2_e = 5'd6;
        hz_if.reg_write_m = 1'b1; hz_if.rd_m = 5'd5;
        hz_if.reg_write_w = 1'b1; hz_if.rd_w = 5'd5;
        #1;
        check_val("fwd_a_m_over_w", 32'(hz_if.forward_a_e), 32'(FORWARD_MEMORY));
        check_val("fwd_b_none", 32'(hz_if.forward_b_e), 32'(FORWARD_NONE));
        hz_if.rd_w = 5'd6;
        hz_if.csrs_e = 12'h300; hz_if.csr_write_w = 1'b1; hz_if.csrs_w = 12'h300;
        #1;
        check_val("fwd_b_w", 32'(hz_if.forward_b_e), 32'(FORWARD_WRITEBACK));
        check_val("fwd_csr_w", 32'(hz_if.forward_csr_e), 32'(FORWARD_WRITEBACK));
        hz_if.rs1_e = 5'd0; hz_if.rd_m = 5'd0;
        #1;
        check_val("fwd_a_x0", 32'(hz_if.forward_a_e), 32'(FORWARD_NONE));
        clr();

        // Load-use
        hz_if.result_src_e = RESULT_SRC_DATA; hz_if.rd_e = 5'd5;
        hz_if.uses_rs1_d = 1'b1; hz_if.rs1_d = 5'd5;
        #1;
        check_val("lw_stall_f", 32'(hz_if.stall_f), 32'd1);
        check_val("lw_stall_d", 32'(hz_if.stall_d), 32'd1);
        check_val("lw_flush_e", 32'(hz_if.flush_e), 32'd1);
        check_val("lw_flush_d", 32'(hz_if.flush_d), 32'd0);
        hz_if.rd_e = 5'd0; hz_if.rs1_d = 5'd0;
        #1;
        check_val("lw_rd0_stall", 32'(hz_if.stall_f), 32'd0);
        clr();

        // Fill the scoreboard with x1..x4
        for (int i = 1; i <= 4; i++) begin
            issue(5'(i));
        end
        check_val("full_count", 32'(hz_if.pending_count), 32'd4);
        hz_if.long_op_d = 1'b1;
        #1;
        check_val("full_long_stall", 32'(hz_if.stall_f), 32'd1);
        hz_if.long_done = 1'b1; hz_if.long_done_rd = 5'd1;
        hz_if.long_issue_e = 1'b1; hz_if.rd_e = 5'd5;
        #1;
        check_val("full_done_nostall", 32'(hz_if.stall_f), 32'd0);
        tick();
        clr();
        check_val("full_pushpop_count", 32'(hz_if.pending_count), 32'd4);
        check_val("full_pushpop_err", 32'(hz_if.sb_error), 32'd0);

        // Table now x2,x3,x4,x5: a reader of x3 stalls until x3 retires
        hz_if.uses_rs1_d = 1'b1; hz_if.rs1_d = 5'd3;
        hz_if.long_done = 1'b1; hz_if.long_done_rd = 5'd2;
        #1;
        check_val("raw_x3_stall_a", 32'(hz_if.stall_d), 32'd1);
        tick();
        hz_if.long_done_rd = 5'd3;
        #1;
        check_val("raw_x3_stall_b", 32'(hz_if.stall_d), 32'd1);
        tick();
        hz_if.long_done = 1'b0;
        #1;
        check_val("raw_x3_released", 32'(hz_if.stall_d), 32'd0);
        check_val("raw_count", 32'(hz_if.pending_count), 32'd2);
        clr();
        hz_if.rd_d = 5'd4;
        #1;
        check_val("waw_stall", 32'(hz_if.stall_f), 32'd1);
        clr();
        hz_if.fence_d = 1'b1;
        #1;
        check_val("fence_stall", 32'(hz_if.stall_f), 32'd1);
        clr();

        // Push+pop at count 2; table becomes x5,x6
        hz_if.long_issue_e = 1'b1; hz_if.rd_e = 5'd6;
        hz_if.long_done = 1'b1; hz_if.long_done_rd = 5'd4;
        tick();
        clr();
        check_val("pushpop2_count", 32'(hz_if.pending_count), 32'd2);

        // Interrupt with two pending ops
        hz_if.int_req = 1'b1;
        #1;
        check_val("int_run_stall", 32'(hz_if.stall_f), 32'd0);
        tick();
        check_val("drain_stall_f", 32'(hz_if.stall_f), 32'd1);
        check_val("drain_stall_d", 32'(hz_if.stall_d), 32'd1);
        check_val("drain_flush_e", 32'(hz_if.flush_e), 32'd1);
        check_val("drain_flush_d", 32'(hz_if.flush_d), 32'd0);
        check_val("drain_take", 32'(hz_if.int_take), 32'd0);
        hz_if.long_done = 1'b1; hz_if.long_done_rd = 5'd5;
        tick();
        check_val("drain1_stall", 32'(hz_if.stall_f), 32'd1);
        check_val("drain1_count", 32'(hz_if.pending_count), 32'd1);
        hz_if.long_done_rd = 5'd6;
        tick();
        hz_if.long_done = 1'b0;
        #1;
        check_val("drain2_take", 32'(hz_if.int_take), 32'd0);
        check_val("drain2_stall", 32'(hz_if.stall_f), 32'd1);
        tick();
        check_val("take_pulse", 32'(hz_if.int_take), 32'd1);
        check_val("take_flush_d", 32'(hz_if.flush_d), 32'd1);
        check_val("take_flush_e", 32'(hz_if.flush_e), 32'd1);
        check_val("take_flush_m", 32'(hz_if.flush_m), 32'd1);
        check_val("take_stall", 32'(hz_if.stall_f), 32'd0);
        hz_if.int_req = 1'b0;
        tick();
        check_val("post_take_take", 32'(hz_if.int_take), 32'd0);
        check_val("post_take_flush_m", 32'(hz_if.flush_m), 32'd0);
        check_val("post_take_err", 32'(hz_if.sb_error), 32'd0);

        // Drop int_req mid-DRAIN
        issue(5'd7);
        hz_if.int_req = 1'b1;
        tick();
        check_val("abort_drain_stall", 32'(hz_if.stall_f), 32'd1);
        hz_if.int_req = 1'b0;
        tick();
        check_val("abort_run_stall", 32'(hz_if.stall_f), 32'd0);
        check_val("abort_take", 32'(hz_if.int_take), 32'd0);
        retire(5'd7);
        check_val("abort_count", 32'(hz_if.pending_count), 32'd0);

        // Interrupt with a redirect in E
        hz_if.int_req = 1'b1; hz_if.pc_src_e = PC_SRC_BRANCH;
        #1;
        check_val("br_flush_d", 32'(hz_if.flush_d), 32'd1);
        check_val("br_flush_e", 32'(hz_if.flush_e), 32'd1);
        tick();
        hz_if.pc_src_e = PC_SRC_PC_PLUS_4;
        #1;
        check_val("br_still_run", 32'(hz_if.stall_f), 32'd0);
        tick();
        check_val("br_then_drain", 32'(hz_if.stall_f), 32'd1);
        hz_if.int_req = 1'b0;
        tick();

        // Protocol errors
        retire(5'd0);
        check_val("pop_empty_err", 32'(hz_if.sb_error), 32'd1);
        check_val("pop_empty_count", 32'(hz_if.pending_count), 32'd0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        check_val("err_cleared", 32'(hz_if.sb_error), 32'd0);
        issue(5'd9);
        retire(5'd8);
        check_val("rd_mismatch_err", 32'(hz_if.sb_error), 32'd1);

        // Reset during DRAIN with three pending
        issue(5'd1);
        issue(5'd2);
        issue(5'd3);
        hz_if.int_req = 1'b1;
        tick();
        check_val("pre_rst_count", 32'(hz_if.pending_count), 32'd3);
        check_val("pre_rst_stall", 32'(hz_if.stall_f), 32'd1);
        rst = 1'b1;
        #1;
        check_val("rst_drain_count", 32'(hz_if.pending_count), 32'd0);
        check_val("rst_drain_stall", 32'(hz_if.stall_f), 32'd0);
        check_val("rst_drain_flush_e", 32'(hz_if.flush_e), 32'd0);
        check_val("rst_drain_take", 32'(hz_if.int_take), 32'd0);
        check_val("rst_drain_err", 32'(hz_if.sb_error), 32'd0);
        hz_if.int_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_val("final_count", 32'(hz_if.pending_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
